// File: rtl/multicycle_core_pkg.sv
// Shared constants for the multi-cycle RV32I-subset core: opcodes, funct3 codes, FSM states.
package multicycle_core_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_WAIT      = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4
  } state_e;

endpackage

// File: rtl/multicycle_core_regfile.sv
// Register file: NREGS x XLEN, two asynchronous read ports, one synchronous write port, x0 hardwired to zero.
module core_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] raddr1_i,
  input  logic [$clog2(NREGS)-1:0] raddr2_i,
  output logic [XLEN-1:0]          rdata1_o,
  output logic [XLEN-1:0]          rdata2_o,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [XLEN-1:0]          wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Clear all registers on reset; discard writes aimed at x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH/WAIT/DECODE/EXECUTE/WRITEBACK with a valid/ready fetch port.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] PC_LIMIT = 32'h100,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] result,
  output logic            retire,
  output logic            illegal
);

  localparam int unsigned     AW         = $clog2(NREGS);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d, npc_q, npc_d, result_q, result_d;
  logic [31:0]     ir_q, ir_d;
  logic            req_q, req_d, wen_q, wen_d, upd_q, upd_d, bad_q, bad_d;
  logic            retire_q, retire_d, illegal_q, illegal_d;
  logic            take;

  logic [XLEN-1:0] rdata1, rdata2, op2, sra_val;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [4:0]      shamt;

  assign opcode  = ir_q[6:0];
  assign f3      = ir_q[14:12];
  assign op2     = (opcode == OP_RTYPE) ? b_q : imm_q;
  assign shamt   = op2[4:0];
  // Kept as its own signal so the arithmetic shift is evaluated in signed context.
  assign sra_val = $signed(a_q) >>> shamt;

  core_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (ir_q[15 +: AW]),
    .raddr2_i (ir_q[20 +: AW]),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .we_i     ((state_q == S_WRITEBACK) && wen_q),
    .waddr_i  (ir_q[7 +: AW]),
    .wdata_i  (alu_q)
  );

  // State and datapath registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      npc_q     <= '0;
      result_q  <= '0;
      req_q     <= 1'b0;
      wen_q     <= 1'b0;
      upd_q     <= 1'b0;
      bad_q     <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      npc_q     <= npc_d;
      result_q  <= result_d;
      req_q     <= req_d;
      wen_q     <= wen_d;
      upd_q     <= upd_d;
      bad_q     <= bad_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, decode, ALU/branch evaluation and write-back control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    npc_d     = npc_q;
    result_d  = result_q;
    req_d     = req_q;
    wen_d     = wen_q;
    upd_d     = upd_q;
    bad_d     = bad_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    take      = 1'b0;
    case (state_q)
      // imem_req is registered, so it is high for the whole WAIT phase and clears on reset.
      S_FETCH: begin
        req_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rdata1;
        b_d = rdata2;
        case (opcode)
          OP_BRANCH: imm_d = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
          OP_JAL:    imm_d = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
          default:   imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        endcase
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        npc_d   = (pc_q + XLEN'(4)) & ALIGN_MASK;
        wen_d   = 1'b0;
        upd_d   = 1'b0;
        bad_d   = 1'b0;
        state_d = S_WRITEBACK;
        case (opcode)
          OP_RTYPE, OP_ITYPE: begin
            wen_d = 1'b1;
            upd_d = 1'b1;
            case (f3)
              F3_ADD:  alu_d = ((opcode == OP_RTYPE) && ir_q[30]) ? (a_q - op2) : (a_q + op2);
              F3_SLL:  alu_d = a_q << shamt;
              F3_SLT:  alu_d = XLEN'($signed(a_q) < $signed(op2));
              F3_SLTU: alu_d = XLEN'(a_q < op2);
              F3_XOR:  alu_d = a_q ^ op2;
              F3_SR:   alu_d = ir_q[30] ? sra_val : (a_q >> shamt);
              F3_OR:   alu_d = a_q | op2;
              default: alu_d = a_q & op2;
            endcase
          end
          OP_JAL: begin
            wen_d = 1'b1;
            upd_d = 1'b1;
            alu_d = pc_q + XLEN'(4);
            npc_d = (pc_q + imm_q) & ALIGN_MASK;
          end
          OP_BRANCH: begin
            case (f3)
              F3_BEQ:  take = (a_q == b_q);
              F3_BNE:  take = (a_q != b_q);
              F3_BLT:  take = ($signed(a_q) < $signed(b_q));
              F3_BGE:  take = ($signed(a_q) >= $signed(b_q));
              F3_BLTU: take = (a_q < b_q);
              F3_BGEU: take = (a_q >= b_q);
              default: bad_d = 1'b1;
            endcase
            if (take) npc_d = (pc_q + imm_q) & ALIGN_MASK;
          end
          default: bad_d = 1'b1;
        endcase
      end
      S_WRITEBACK: begin
        pc_d      = (npc_q >= PC_LIMIT) ? RESET_PC : npc_q;
        if (upd_q) result_d = alu_q;
        retire_d  = 1'b1;
        illegal_d = bad_q;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign result    = result_q;
  assign retire    = retire_q;
  assign illegal   = illegal_q;

endmodule
